usb_in_ep_arbiter: RTL and testbench

//  Shares the single USB IN endpoint buffer between NUM_EP requesting endpoints (EP0 control + bulk/vendor EPs).

---
 rtl/usb_in_arb_pkg.sv | 13 +
 rtl/usb_rr_pick.sv | 35 +++
 rtl/usb_in_ep_arbiter.sv | 159 +++++++++++++++
 tb/tb_usb_in_ep_arbiter.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_in_arb_pkg.sv
// Shared definitions for the USB IN endpoint arbiter: FSM state encoding and EP index width helper.
// Combinational only; no latency or backpressure of its own.
package usb_in_arb_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  function automatic int ep_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/usb_rr_pick.sv
// Round-robin priority picker: first requester at or after ptr (wrapping), as one-hot plus index.
// Purely combinational, zero latency; no backpressure.
module usb_rr_pick
  import usb_in_arb_pkg::*;
#(
  parameter int NUM_EP = 4,
  parameter int IDX_W  = ep_idx_w(NUM_EP)
) (
  input  logic [NUM_EP-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_EP-1:0] gnt_oh,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic              any
);

  logic [IDX_W-1:0] pos;

  // Scan farthest-to-nearest so the nearest requester at/after ptr is the last write.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    any     = 1'b0;
    pos     = '0;
    for (int k = NUM_EP - 1; k >= 0; k--) begin
      pos = IDX_W'((int'(ptr) + k) % NUM_EP);
      if (req[pos]) begin
        gnt_oh      = '0;
        gnt_oh[pos] = 1'b1;
        gnt_idx     = pos;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_in_ep_arbiter.sv
// Round-robin owner of the shared USB IN buffer; grant one cycle after request, held a whole packet, two dead cycles between grants.
// Backpressure: granted EP's put is gated by buf_data_free; optional watchdog via USB_IN_ARB_TIMEOUT_EN.
module usb_in_ep_arbiter
  import usb_in_arb_pkg::*;
#(
  parameter int NUM_EP         = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_EP-1:0]        ep_req,
  output logic [NUM_EP-1:0]        ep_grant,
  input  logic [NUM_EP-1:0]        ep_data_put,
  input  logic [NUM_EP*DATA_W-1:0] ep_data,
  input  logic [NUM_EP-1:0]        ep_data_done,
  input  logic [NUM_EP-1:0]        ep_stall,
  output logic [NUM_EP-1:0]        ep_data_free,
  output logic [NUM_EP-1:0]        ep_acked,
  input  logic                     buf_data_free,
  output logic                     buf_data_put,
  output logic [DATA_W-1:0]        buf_data,
  output logic                     buf_data_done,
  output logic                     buf_stall,
  input  logic                     buf_acked,
  output logic [2:0]               buf_ep_num,
  output logic                     busy
);

  localparam int IDX_W = ep_idx_w(NUM_EP);

  logic [1:0]        state_q, state_d;
  logic [NUM_EP-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]  g_q, g_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [IDX_W-1:0]  served_q, served_d;

  logic [NUM_EP-1:0] pick_oh;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;

  logic sel_put, sel_done, sel_stall, sel_req;
  logic timeout_hit;
  logic exit_evt;

  usb_rr_pick #(
    .NUM_EP (NUM_EP),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req     (ep_req),
    .ptr     (rr_q),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  assign busy      = (state_q == ST_GRANT);
  assign sel_put   = ep_data_put[g_q];
  assign sel_done  = ep_data_done[g_q];
  assign sel_stall = ep_stall[g_q];
  assign sel_req   = ep_req[g_q];

`ifdef USB_IN_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any forwarded byte proves the EP is alive, so it restarts the watchdog.
  always_comb begin
    cnt_d = cnt_q;
    if (!busy || buf_data_put) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign timeout_hit = busy && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign timeout_hit    = 1'b0;
`endif

  assign exit_evt = sel_done | sel_stall | ~sel_req | timeout_hit;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    g_d      = g_q;
    rr_d     = rr_q;
    served_d = served_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_GRANT;
          grant_d = pick_oh;
          g_d     = pick_idx;
        end
      end
      ST_GRANT: begin
        if (exit_evt) begin
          state_d = ST_RELEASE;
          grant_d = '0;
          rr_d    = (g_q == IDX_W'(NUM_EP - 1)) ? '0 : g_q + 1'b1;
          // Only a committed packet can be ACKed, so only commits move the ACK route.
          if (sel_done || timeout_hit) begin
            served_d = g_q;
          end
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      g_q      <= '0;
      rr_q     <= '0;
      served_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      g_q      <= g_d;
      rr_q     <= rr_d;
      served_q <= served_d;
    end
  end

  assign ep_grant      = grant_q;
  assign buf_ep_num    = 3'(g_q);
  assign buf_data_put  = busy & sel_put & buf_data_free;
  assign buf_data      = ep_data[g_q*DATA_W +: DATA_W];
  assign buf_data_done = busy & (sel_done | timeout_hit);
  assign buf_stall     = busy & sel_stall;
  assign ep_data_free  = busy ? (grant_q & {NUM_EP{buf_data_free}}) : '0;

  always_comb begin
    ep_acked           = '0;
    ep_acked[served_q] = buf_acked;
  end

endmodule

// File: tb/tb_usb_in_ep_arbiter.sv
// Directed bench for usb_in_ep_arbiter; timeout scenario built when USB_IN_ARB_TIMEOUT_EN is defined.
module tb_usb_in_ep_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    ep_req;
  logic [N-1:0]    ep_grant;
  logic [N-1:0]    ep_data_put;
  logic [N*DW-1:0] ep_data;
  logic [N-1:0]    ep_data_done;
  logic [N-1:0]    ep_stall;
  logic [N-1:0]    ep_data_free;
  logic [N-1:0]    ep_acked;
  logic            buf_data_free;
  logic            buf_data_put;
  logic [DW-1:0]   buf_data;
  logic            buf_data_done;
  logic            buf_stall;
  logic            buf_acked;
  logic [2:0]      buf_ep_num;
  logic            busy;

  int checks = 0;
  int errors = 0;

  usb_in_ep_arbiter #(
    .NUM_EP         (N),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ep_req        (ep_req),
    .ep_grant      (ep_grant),
    .ep_data_put   (ep_data_put),
    .ep_data       (ep_data),
    .ep_data_done  (ep_data_done),
    .ep_stall      (ep_stall),
    .ep_data_free  (ep_data_free),
    .ep_acked      (ep_acked),
    .buf_data_free (buf_data_free),
    .buf_data_put  (buf_data_put),
    .buf_data      (buf_data),
    .buf_data_done (buf_data_done),
    .buf_stall     (buf_stall),
    .buf_acked     (buf_acked),
    .buf_ep_num    (buf_ep_num),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    ep_req        = '0;
    ep_data_put   = '0;
    ep_data       = '0;
    ep_data_done  = '0;
    ep_stall      = '0;
    buf_data_free = 1'b1;
    buf_acked     = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_inputs();
    #2;
    checks++;
    if ({ep_grant, busy, buf_ep_num} !== 8'b0) begin
      errors++;
      $display("FAIL reset_state got grant=%b busy=%b ep_num=%0d want 0/0/0", ep_grant, busy, buf_ep_num);
    end
    checks++;
    if ({buf_data_put, buf_data_done, buf_stall, ep_data_free} !== 7'b0) begin
      errors++;
      $display("FAIL reset_strobes got put=%b done=%b stall=%b free=%b want all 0",
               buf_data_put, buf_data_done, buf_stall, ep_data_free);
    end
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    int exp_order [5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] exp_g;
    logic [DW-1:0] val;
    ep_req = 4'b1111;
    for (int i = 0; i < N; i++) ep_data[i*DW +: DW] = 8'(8'hF0 + i);
    tick();
    for (int r = 0; r < 5; r++) begin
      int e;
      e = exp_order[r];
      exp_g = '0;
      exp_g[e] = 1'b1;
      settle();
      checks++;
      if (ep_grant !== exp_g || buf_ep_num !== 3'(e) || busy !== 1'b1) begin
        errors++;
        $display("FAIL rr_grant round %0d got grant=%b ep_num=%0d busy=%b want grant=%b ep_num=%0d busy=1",
                 r, ep_grant, buf_ep_num, busy, exp_g, e);
      end
      for (int b = 0; b < 3; b++) begin
        val = 8'(e * 16 + b + r);
        ep_data[e*DW +: DW] = val;
        ep_data_put[e] = 1'b1;
        settle();
        checks++;
        if (buf_data_put !== 1'b1 || buf_data !== val) begin
          errors++;
          $display("FAIL rr_byte ep %0d byte %0d got put=%b data=%h want put=1 data=%h",
                   e, b, buf_data_put, buf_data, val);
        end
        tick();
      end
      ep_data_put = '0;
      ep_data_done[e] = 1'b1;
      settle();
      checks++;
      if (buf_data_done !== 1'b1) begin
        errors++;
        $display("FAIL rr_done ep %0d got %b want 1", e, buf_data_done);
      end
      tick();
      ep_data_done = '0;
      buf_acked = 1'b1;
      settle();
      checks++;
      if (ep_grant !== 4'b0 || busy !== 1'b0 || ep_acked !== exp_g) begin
        errors++;
        $display("FAIL rr_release ep %0d got grant=%b busy=%b acked=%b want 0000/0/%b",
                 e, ep_grant, busy, ep_acked, exp_g);
      end
      buf_acked = 1'b0;
      if (r == 4) ep_req = '0;
      tick();
      checks++;
      if (ep_grant !== 4'b0) begin
        errors++;
        $display("FAIL rr_dead_cycle round %0d got grant=%b want 0000", r, ep_grant);
      end
      tick();
    end
    tick();
  endtask

  task automatic test_isolation();
    clear_inputs();
    ep_req = 4'b0010;
    ep_data[1*DW +: DW] = 8'h11;
    ep_data[3*DW +: DW] = 8'hA5;
    tick();
    settle();
    checks++;
    if (ep_grant !== 4'b0010) begin
      errors++;
      $display("FAIL iso_grant got %b want 0010", ep_grant);
    end
    for (int c = 0; c < 3; c++) begin
      ep_data_put[3]  = 1'b1;
      ep_data_done[3] = 1'b1;
      ep_stall[3]     = 1'b1;
      ep_req[3]       = c[0];
      settle();
      checks++;
      if (buf_data_put !== 1'b0 || buf_data_done !== 1'b0 || buf_stall !== 1'b0 ||
          buf_data !== 8'h11 || ep_data_free !== 4'b0010) begin
        errors++;
        $display("FAIL iso_leak cycle %0d got put=%b done=%b stall=%b data=%h free=%b want 0/0/0/11/0010",
                 c, buf_data_put, buf_data_done, buf_stall, buf_data, ep_data_free);
      end
      tick();
    end
    ep_data_put = 4'b0010;
    ep_data_done = '0;
    ep_stall = '0;
    ep_req = 4'b0010;
    settle();
    checks++;
    if (ep_grant !== 4'b0010 || buf_data_put !== 1'b1 || buf_data !== 8'h11) begin
      errors++;
      $display("FAIL iso_own_put got grant=%b put=%b data=%h want 0010/1/11", ep_grant, buf_data_put, buf_data);
    end
    tick();
    ep_data_put = '0;
    ep_req = '0;
    tick();
    buf_acked = 1'b1;
    settle();
    checks++;
    if (ep_grant !== 4'b0 || ep_acked !== 4'b0001) begin
      errors++;
      $display("FAIL iso_req_drop got grant=%b acked=%b want 0000/0001", ep_grant, ep_acked);
    end
    buf_acked = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_backpressure();
    clear_inputs();
    ep_req = 4'b0001;
    tick();
    settle();
    checks++;
    if (ep_grant !== 4'b0001) begin
      errors++;
      $display("FAIL bp_grant got %b want 0001", ep_grant);
    end
    ep_data[0 +: DW] = 8'h5C;
    ep_data_put = 4'b0001;
    buf_data_free = 1'b0;
    for (int c = 0; c < 5; c++) begin
      settle();
      checks++;
      if (buf_data_put !== 1'b0 || ep_data_free !== 4'b0000) begin
        errors++;
        $display("FAIL bp_blocked cycle %0d got put=%b free=%b want 0/0000", c, buf_data_put, ep_data_free);
      end
      tick();
    end
    buf_data_free = 1'b1;
    settle();
    checks++;
    if (buf_data_put !== 1'b1 || ep_data_free !== 4'b0001 || buf_data !== 8'h5C) begin
      errors++;
      $display("FAIL bp_resume got put=%b free=%b data=%h want 1/0001/5c", buf_data_put, ep_data_free, buf_data);
    end
    tick();
    ep_data[0 +: DW] = 8'h5D;
    ep_data_done = 4'b0001;
    settle();
    checks++;
    if (buf_data_put !== 1'b1 || buf_data_done !== 1'b1 || buf_data !== 8'h5D) begin
      errors++;
      $display("FAIL bp_put_done got put=%b done=%b data=%h want 1/1/5d", buf_data_put, buf_data_done, buf_data);
    end
    tick();
    clear_inputs();
    settle();
    checks++;
    if (ep_grant !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got grant=%b busy=%b want 0000/0", ep_grant, busy);
    end
    tick();
    tick();
  endtask

  task automatic test_stall();
    clear_inputs();
    ep_req = 4'b0001;
    tick();
    ep_req = 4'b0011;
    ep_stall = 4'b0001;
    settle();
    checks++;
    if (ep_grant !== 4'b0001 || buf_stall !== 1'b1) begin
      errors++;
      $display("FAIL stall_fwd got grant=%b stall=%b want 0001/1", ep_grant, buf_stall);
    end
    tick();
    ep_stall = '0;
    settle();
    checks++;
    if (ep_grant !== 4'b0 || buf_stall !== 1'b0) begin
      errors++;
      $display("FAIL stall_drop got grant=%b stall=%b want 0000/0", ep_grant, buf_stall);
    end
    tick();
    checks++;
    if (ep_grant !== 4'b0) begin
      errors++;
      $display("FAIL stall_gap got grant=%b want 0000", ep_grant);
    end
    tick();
    checks++;
    if (ep_grant !== 4'b0010 || buf_ep_num !== 3'd1) begin
      errors++;
      $display("FAIL stall_next got grant=%b ep_num=%0d want 0010/1", ep_grant, buf_ep_num);
    end
    ep_stall = 4'b0001;
    settle();
    checks++;
    if (buf_stall !== 1'b0) begin
      errors++;
      $display("FAIL stall_leak got %b want 0", buf_stall);
    end
    tick();
    ep_stall = '0;
    ep_data_done = 4'b0010;
    settle();
    checks++;
    if (ep_grant !== 4'b0010 || buf_data_done !== 1'b1 || buf_data_put !== 1'b0) begin
      errors++;
      $display("FAIL zlp_done got grant=%b done=%b put=%b want 0010/1/0", ep_grant, buf_data_done, buf_data_put);
    end
    tick();
    clear_inputs();
    buf_acked = 1'b1;
    settle();
    checks++;
    if (ep_grant !== 4'b0 || ep_acked !== 4'b0010) begin
      errors++;
      $display("FAIL zlp_acked got grant=%b acked=%b want 0000/0010", ep_grant, ep_acked);
    end
    buf_acked = 1'b0;
    tick();
    tick();
  endtask

`ifdef USB_IN_ARB_TIMEOUT_EN
  task automatic test_timeout();
    clear_inputs();
    ep_req = 4'b0010;
    tick();
    for (int k = 1; k <= 16; k++) begin
      settle();
      checks++;
      if (ep_grant !== 4'b0010 || buf_data_done !== (k == 16)) begin
        errors++;
        $display("FAIL timeout cycle %0d got grant=%b done=%b want 0010/%b", k, ep_grant, buf_data_done, (k == 16));
      end
      tick();
    end
    checks++;
    if (ep_grant !== 4'b0) begin
      errors++;
      $display("FAIL timeout_release got grant=%b want 0000", ep_grant);
    end
  endtask
`else
  task automatic test_hold();
    logic saw_done;
    saw_done = 1'b0;
    clear_inputs();
    ep_req = 4'b0010;
    tick();
    for (int k = 0; k < 40; k++) begin
      if (buf_data_done !== 1'b0) saw_done = 1'b1;
      tick();
    end
    checks++;
    if (ep_grant !== 4'b0010 || saw_done !== 1'b0) begin
      errors++;
      $display("FAIL hold got grant=%b saw_done=%b want 0010/0", ep_grant, saw_done);
    end
  endtask
`endif

  task automatic test_reset_mid_grant();
    bit found;
    found = 1'b0;
    ep_req = 4'b0100;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      if (ep_grant === 4'b0100) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_reset_setup got grant=%b want 0100 within 10 cycles", ep_grant);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (ep_grant !== 4'b0 || busy !== 1'b0 || buf_ep_num !== 3'd0) begin
      errors++;
      $display("FAIL mid_reset got grant=%b busy=%b ep_num=%0d want 0000/0/0", ep_grant, busy, buf_ep_num);
    end
    clear_inputs();
    tick();
    reset_n = 1'b1;
    tick();
    ep_req = 4'b1010;
    tick();
    checks++;
    if (ep_grant !== 4'b0010) begin
      errors++;
      $display("FAIL post_reset_ptr got grant=%b want 0010", ep_grant);
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_isolation();
    test_backpressure();
    test_stall();
`ifdef USB_IN_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_hold();
`endif
    test_reset_mid_grant();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
